// File: rtl/tt_response_checker.sv
// tt_response_checker
// Observing end of an exhaustive-stimulus flow. Each valid (vector, response)
// sample is checked against a parameterised expected truth table while the
// block tracks input-space coverage, counts mismatches and latches the first
// failure. done/pass are raised once every table row has been sampled.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   start           one-cycle pulse: clear all results and arm checking
//   smp_valid       sample strobe; smp_vec / smp_resp settled this cycle
//   smp_vec         input vector applied to the unit under test
//   smp_resp        observed outputs of the unit under test
//   busy / done     state decode: RUN / DONE
//   pass            done with zero mismatches (combinational)
//   err_cnt         saturating mismatch count
//   smp_cnt         saturating accepted-sample count
//   cov_map         bit i set once row i has been sampled
//   first_err_*     vector, response and valid flag of the first mismatch
module tt_response_checker #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 2,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXP_TABLE = 16'hD668,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   smp_valid,
    input  logic [N_IN-1:0]        smp_vec,
    input  logic [N_OUT-1:0]       smp_resp,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       smp_cnt,
    output logic [(2**N_IN)-1:0]   cov_map,
    output logic [N_IN-1:0]        first_err_vec,
    output logic [N_OUT-1:0]       first_err_got,
    output logic                   first_err_vld
);

    localparam int unsigned ROWS = 2**N_IN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Expected table split into one entry per row, indexed by input vector.
    logic [N_OUT-1:0] exp_rows [ROWS];

    for (genvar g = 0; g < ROWS; g++) begin : g_rows
        assign exp_rows[g] = EXP_TABLE[g*N_OUT +: N_OUT];
    end

    logic             accept;
    logic             mismatch;
    logic [N_OUT-1:0] exp_row;
    logic [ROWS-1:0]  vec_onehot;
    logic [ROWS-1:0]  cov_upd;
    logic             cov_full;

    // Sample qualification, table lookup and post-sample coverage.
    // start wins over a coincident sample so a restart never counts it.
    always_comb begin
        accept     = (state == ST_RUN) && smp_valid && !start;
        exp_row    = exp_rows[smp_vec];
        mismatch   = (smp_resp != exp_row);
        vec_onehot = ROWS'(1) << smp_vec;
        cov_upd    = cov_map | vec_onehot;
        cov_full   = &cov_upd;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completion is judged on coverage including the
    // sample being accepted so DONE lands on the same edge as the last bit.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start) begin
                    state_next = ST_RUN;
                end else if (accept && cov_full) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign pass = done && (err_cnt == '0);

    // Result registers: cleared by reset or start, updated per accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt       <= '0;
            smp_cnt       <= '0;
            cov_map       <= '0;
            first_err_vec <= '0;
            first_err_got <= '0;
            first_err_vld <= 1'b0;
        end else if (start) begin
            err_cnt       <= '0;
            smp_cnt       <= '0;
            cov_map       <= '0;
            first_err_vec <= '0;
            first_err_got <= '0;
            first_err_vld <= 1'b0;
        end else if (accept) begin
            if (smp_cnt != {CNT_W{1'b1}}) begin
                smp_cnt <= smp_cnt + CNT_W'(1);
            end
            cov_map <= cov_upd;
            if (mismatch) begin
                if (err_cnt != {CNT_W{1'b1}}) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
                if (!first_err_vld) begin
                    first_err_vec <= smp_vec;
                    first_err_got <= smp_resp;
                    first_err_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_response_checker.sv
// Scoreboard bench for tt_response_checker (default full-adder table).
// The driver pushes the expected post-edge result snapshot for every cycle it
// drives, plus hand-computed checkpoints; a monitor pops and compares.
module tb_tt_response_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       smp_valid;
    logic [2:0] smp_vec;
    logic [1:0] smp_resp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [7:0] smp_cnt;
    logic [7:0] cov_map;
    logic [2:0] first_err_vec;
    logic [1:0] first_err_got;
    logic       first_err_vld;

    tt_response_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .smp_valid     (smp_valid),
        .smp_vec       (smp_vec),
        .smp_resp      (smp_resp),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .smp_cnt       (smp_cnt),
        .cov_map       (cov_map),
        .first_err_vec (first_err_vec),
        .first_err_got (first_err_got),
        .first_err_vld (first_err_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full adder {sum, carry} for inputs 0..7.
    logic [1:0] fa [0:7];
    initial fa = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    typedef struct {
        int          cyc;
        string       name;
        logic [32:0] v;
    } chk_t;

    logic [32:0] q [$];
    chk_t        hq [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          drive_cnt = 0;
    int          pop_cnt = 0;

    // Bench reference state (value after the next edge).
    int         m_state = 0; // 0 idle, 1 run, 2 done
    logic [7:0] m_err = 8'h00;
    logic [7:0] m_smp = 8'h00;
    logic [7:0] m_cov = 8'h00;
    logic       m_fv = 1'b0;
    logic [2:0] m_fvec = 3'd0;
    logic [1:0] m_fgot = 2'd0;

    function automatic logic [32:0] pk(input logic b, input logic d, input logic p,
                                       input logic [7:0] e, input logic [7:0] s,
                                       input logic [7:0] c, input logic fv,
                                       input logic [2:0] fvec, input logic [1:0] fgot);
        return {b, d, p, e, s, c, fv, fvec, fgot};
    endfunction

    task automatic cmp(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h (b/d/p err smp cov fv fvec fgot) want %h", name, got, exp);
        end
    endtask

    // Drive one cycle and push the expected snapshot after its edge.
    task automatic drive(input logic r, input logic s, input logic v,
                         input logic [2:0] vec, input logic [1:0] resp);
        @(negedge clk);
        rst_n     = r;
        start     = s;
        smp_valid = v;
        smp_vec   = vec;
        smp_resp  = resp;
        if (!r) begin
            m_state = 0; m_err = 0; m_smp = 0; m_cov = 0;
            m_fv = 0; m_fvec = 0; m_fgot = 0;
        end else if (s) begin
            m_state = 1; m_err = 0; m_smp = 0; m_cov = 0;
            m_fv = 0; m_fvec = 0; m_fgot = 0;
        end else if (m_state == 1 && v) begin
            if (m_smp != 8'hFF) m_smp = m_smp + 8'd1;
            m_cov[vec] = 1'b1;
            if (resp != fa[vec]) begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                if (!m_fv) begin
                    m_fv = 1'b1; m_fvec = vec; m_fgot = resp;
                end
            end
            if (m_cov == 8'hFF) m_state = 2;
        end
        q.push_back(pk(m_state == 1, m_state == 2, (m_state == 2) && (m_err == 0),
                       m_err, m_smp, m_cov, m_fv, m_fvec, m_fgot));
        drive_cnt++;
        @(posedge clk);
    endtask

    // Hand-computed expectation for the cycle just driven.
    task automatic hand(input string name, input logic [32:0] v);
        chk_t c;
        c.cyc  = drive_cnt - 1;
        c.name = name;
        c.v    = v;
        hq.push_back(c);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
    endtask

    // Monitor: compare DUT results against the queued expectations.
    logic [32:0] got;
    logic [32:0] exp_v;
    chk_t        hc;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            got = {busy, done, pass, err_cnt, smp_cnt, cov_map,
                   first_err_vld, first_err_vec, first_err_got};
            exp_v = q.pop_front();
            cmp($sformatf("cycle%0d", pop_cnt), got, exp_v);
            if (hq.size() > 0 && hq[0].cyc == pop_cnt) begin
                hc = hq.pop_front();
                cmp(hc.name, got, hc.v);
            end
            pop_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; smp_valid = 1'b0; smp_vec = 3'd0; smp_resp = 2'd0;

        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        drive(1'b0, 1'b1, 1'b1, 3'd3, 2'd3);
        hand("reset", pk(0, 0, 0, 8'd0, 8'd0, 8'h00, 0, 3'd0, 2'd0));

        // Clean run, rows in order.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 3'(i), fa[i]);
        hand("clean_run", pk(0, 1, 1, 8'd0, 8'd8, 8'hFF, 0, 3'd0, 2'd0));

        // Wrong samples in DONE are ignored.
        drive(1'b1, 1'b0, 1'b1, 3'd3, 2'b00);
        drive(1'b1, 1'b0, 1'b1, 3'd7, 2'b00);
        hand("done_ignore", pk(0, 1, 1, 8'd0, 8'd8, 8'hFF, 0, 3'd0, 2'd0));

        // Faulty run: row 5 -> 11, row 6 -> 00.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        hand("restart_clean", pk(1, 0, 0, 8'd0, 8'd0, 8'h00, 0, 3'd0, 2'd0));
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b0, 1'b1, 3'(i), (i == 5) ? 2'b11 : (i == 6) ? 2'b00 : fa[i]);
        hand("faulty_run", pk(0, 1, 0, 8'd2, 8'd8, 8'hFF, 1, 3'd5, 2'b11));

        // Start together with a sample in DONE: sample ignored, all clear.
        drive(1'b1, 1'b1, 1'b1, 3'd2, 2'b11);
        hand("start_with_smp", pk(1, 0, 0, 8'd0, 8'd0, 8'h00, 0, 3'd0, 2'd0));

        // Duplicate row 0, row 7 missing.
        drive(1'b1, 1'b0, 1'b1, 3'd0, 2'b00);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b1, 3'(i), fa[i]);
        hand("row7_missing", pk(1, 0, 0, 8'd0, 8'd8, 8'h7F, 0, 3'd0, 2'd0));
        idle();
        drive(1'b1, 1'b0, 1'b1, 3'd7, 2'b11);
        hand("row7_done", pk(0, 1, 1, 8'd0, 8'd9, 8'hFF, 0, 3'd0, 2'd0));

        // Start with a sample in RUN is ignored, then reset after 4 samples.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        drive(1'b1, 1'b1, 1'b1, 3'd1, 2'b00);
        hand("start_in_run", pk(1, 0, 0, 8'd0, 8'd0, 8'h00, 0, 3'd0, 2'd0));
        drive(1'b1, 1'b0, 1'b1, 3'd0, 2'b00);
        drive(1'b1, 1'b0, 1'b1, 3'd1, 2'b01);
        drive(1'b1, 1'b0, 1'b1, 3'd2, 2'b10);
        drive(1'b1, 1'b0, 1'b1, 3'd3, 2'b01);
        hand("four_samples", pk(1, 0, 0, 8'd1, 8'd4, 8'h0F, 1, 3'd1, 2'b01));
        drive(1'b0, 1'b0, 1'b1, 3'd4, 2'b00);
        hand("reset_mid_run", pk(0, 0, 0, 8'd0, 8'd0, 8'h00, 0, 3'd0, 2'd0));
        for (int i = 4; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 3'(i), ~fa[i]);
        hand("idle_ignore", pk(0, 0, 0, 8'd0, 8'd0, 8'h00, 0, 3'd0, 2'd0));

        // Saturation: 260 failing samples of row 0.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 260; i++) drive(1'b1, 1'b0, 1'b1, 3'd0, 2'b11);
        hand("saturate", pk(1, 0, 0, 8'hFF, 8'hFF, 8'h01, 1, 3'd0, 2'b11));

        idle();
        idle();
        @(posedge clk);
        #3;
        cmp("queue_drain", {31'd0, q.size() == 0, hq.size() == 0}, 33'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
